// File: rtl/mpu_hm_arbiter.sv
// mpu_hm_arbiter: round-robin sharing of one host-memory read port among NREQ MPUs, with a watchdog abort
module mpu_hm_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [NREQ-1:0]      req_start,
   input  logic [NREQ*64-1:0]   req_addr,
   output logic [NREQ-1:0]      req_ack,
   output logic [63:0]          req_data,
   output logic                 req_err,
   output logic [63:0]          hm_addr,
   output logic                 hm_start,
   input  logic [63:0]          hm_data,
   input  logic                 hm_ack,
   output logic                 busy,
   output logic [7:0]           timeout_cnt
);
   localparam int LW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] pending_q, pending_d, done_mask;
   logic [63:0]     addr_q [NREQ];
   logic [63:0]     addr_d [NREQ];
   logic [LW-1:0]   last_grant_q, last_grant_d, rr_gnt, rr_idx;
   logic            rr_hit;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [63:0]     hm_addr_q, hm_addr_d, req_data_q, req_data_d;
   logic            hm_start_q, hm_start_d, req_err_q, req_err_d;
   logic [NREQ-1:0] req_ack_q, req_ack_d;
   logic [7:0]      timeout_cnt_q, timeout_cnt_d;

   // Round-robin pick: scan downwards so the closest pending index after last_grant is kept
   always_comb begin
      rr_gnt = last_grant_q;
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         rr_idx = LW'((int'(last_grant_q) + k) % NREQ);
         if (pending_q[rr_idx]) begin
            rr_hit = 1'b1;
            rr_gnt = rr_idx;
         end
      end
   end

   // Transaction FSM plus request capture; a pulse coinciding with its own completion re-arms the slot
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      last_grant_d  = last_grant_q;
      tmr_d         = tmr_q;
      hm_addr_d     = hm_addr_q;
      hm_start_d    = 1'b0;
      req_data_d    = req_data_q;
      req_err_d     = 1'b0;
      timeout_cnt_d = timeout_cnt_q;
      done_mask     = '0;
      case (state_q)
         IDLE: if (rr_hit) begin
            hm_addr_d    = addr_q[rr_gnt];
            hm_start_d   = 1'b1;
            last_grant_d = rr_gnt;
            tmr_d        = '0;
            state_d      = WAIT;
         end
         WAIT: begin
            tmr_d = tmr_q + 1'b1;
            if (hm_ack) begin
               req_data_d              = hm_data;
               done_mask[last_grant_q] = 1'b1;
               state_d                 = DONE;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
               req_data_d              = '0;
               req_err_d               = 1'b1;
               done_mask[last_grant_q] = 1'b1;
               timeout_cnt_d           = (timeout_cnt_q == 8'hFF) ? timeout_cnt_q : timeout_cnt_q + 1'b1;
               state_d                 = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ack_d = done_mask;
      for (int i = 0; i < NREQ; i++) begin
         if (req_start[i] && (!pending_q[i] || done_mask[i])) addr_d[i] = req_addr[64*i +: 64];
      end
      pending_d = (pending_q & ~done_mask) | (req_start & (~pending_q | done_mask));
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q       <= IDLE;
         pending_q     <= '0;
         for (int i = 0; i < NREQ; i++) addr_q[i] <= '0;
         last_grant_q  <= LW'(NREQ - 1);
         tmr_q         <= '0;
         hm_addr_q     <= '0;
         hm_start_q    <= 1'b0;
         req_ack_q     <= '0;
         req_data_q    <= '0;
         req_err_q     <= 1'b0;
         timeout_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         addr_q        <= addr_d;
         last_grant_q  <= last_grant_d;
         tmr_q         <= tmr_d;
         hm_addr_q     <= hm_addr_d;
         hm_start_q    <= hm_start_d;
         req_ack_q     <= req_ack_d;
         req_data_q    <= req_data_d;
         req_err_q     <= req_err_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign hm_addr     = hm_addr_q;
   assign hm_start    = hm_start_q;
   assign req_ack     = req_ack_q;
   assign req_data    = req_data_q;
   assign req_err     = req_err_q;
   assign timeout_cnt = timeout_cnt_q;
   assign busy        = (state_q != IDLE);
endmodule
